throw_trajectory: RTL and testbench
===================================

Name: throw_trajectory

Overview:
- Consumes the power-bar stage's throw_force and space key.
- On space release, launches a projectile from the player position.
- Steps the projectile once per frame with fixed-point ballistic physics and gravity.
- Reports position, visibility and landing/out-of-bounds events to the sprite-drawing and game-logic stages downstream.

Parameters:
X_LAUNCH, 876, launch x in pixels
Y_LAUNCH, 600, launch y in pixels
GROUND_Y, 600, landing line; y >= GROUND_Y means landed
H_RES, 1024, horizontal screen width; x outside [0, H_RES) means out of bounds
VX_GAIN, 2, vx = force*VX_GAIN, in 1/16 px/frame, directed leftward
VY_GAIN, 2, vy0 = -(force*VY_GAIN), in 1/16 px/frame
G_Q, 4, gravity added to vy each frame, in 1/16 px/frame²
HOLD_FRAMES, 30, frames the landed projectile stays shown

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
space  in  1  space key level, same signal the power bar uses
throw_force  in  10  force from power bar (0..128)
vsync  in  1  VGA vsync; rising edge = frame tick
proj_x  out  11  projectile pixel x (integer part)
proj_y  out  11  projectile pixel y (integer part); 0 when y<0
proj_on  out  1  projectile exists (FLIGHT or HOLD)
proj_visible  out  1  proj_on and y >= 0
busy  out  1  state != IDLE
landed  out  1  1-cycle pulse on landing
out_of_bounds  out  1  1-cycle pulse on leaving the screen
land_x  out  11  x of last landing, held until the next landing

Behaviour:
- Reset state:
  - All outputs 0; land_x = 0; state IDLE.
  - Internal edge registers cleared: space_d = 0, vsync_d = 0.
- Fixed point:
  - x, y signed 16-bit Q12.4.
  - vx, vy signed 16-bit Q12.4.
  - proj_x/proj_y = integer part (>>4), truncated.
- Release detection: release = space_d && !space, registered compare.
- throw_force is valid one cycle after the release cycle. ARM therefore samples it on the cycle after release is detected.
- FSM:
  - IDLE:
    - on release -> ARM.
  - ARM (1 cycle):
    - f = throw_force.
    - If f == 0 -> IDLE; no launch, no pulse.
    - Else: x = X_LAUNCH<<4, y = Y_LAUNCH<<4, vx = f*VX_GAIN, vy = -(f*VY_GAIN); -> FLIGHT.
  - FLIGHT, on each vsync rising edge (one update per frame):
    - x -= vx; y += vy; vy += G_Q (positions use pre-increment vy).
    - Then check, in priority order:
      1. x < 0 or x >= H_RES<<4: pulse out_of_bounds, -> IDLE.
      2. y >= GROUND_Y<<4: clamp y = GROUND_Y<<4, land_x = x>>4, pulse landed, reset frame counter, -> HOLD.
    - Out-of-bounds wins when both conditions hold in the same frame.
  - HOLD:
    - Count vsync rising edges; after HOLD_FRAMES -> IDLE.
- Frame-tick timing:
  - A vsync tick coinciding with ARM is ignored.
  - The first update happens on the first tick seen while in FLIGHT.
- Space press/release while busy is ignored; no queuing.
- Outputs are registered, updated the cycle after the state/position update.
- Pulses are exactly one clk wide.
- Reset asserted mid-flight: immediate return to reset values; no pulse emitted.
- vy magnitude is bounded by 16 bits for force <= 1023 at default gains. No saturation is required.

Decomposition:
- Package throw_pkg:
  - state enum (IDLE, ARM, FLIGHT, HOLD)
  - FRAC_BITS = 4
  - Q12.4 position/velocity typedefs
  - force width constant 10
- Sub-module edge_detector: parameterised rising/falling edge with registered input.
  - Used for the space release.
  - Used for the vsync rise.

Test Plan:
- Reset: rst_n low mid-sim -> all outputs 0, busy 0, land_x 0. Release rst_n, no stimulus -> stays IDLE.
- Force 64 (defaults): hold space, release, throw_force = 64 -> busy after 1 cycle.
  - landed pulses after the 65th vsync tick.
  - land_x = 356, proj_y = 600, proj_on held 30 frames then 0.
- Force 128: -> out_of_bounds pulse after the 55th tick (x = -4 px). No landed pulse, return to IDLE, land_x unchanged.
- Force 0: release with throw_force = 0 -> ARM for 1 cycle then IDLE. proj_on never high, no pulses.
- Busy lockout: during FLIGHT of a force-64 throw, press and release space with force 100 -> trajectory unaffected, still lands at tick 65, x = 356.
- Reset mid-flight and edge timing: rst_n low at tick 20 -> outputs 0 immediately, no pulse. Relaunch with a vsync tick in the ARM cycle -> that tick is not counted, landing still at the 65th subsequent tick.

Source files
------------

// File: rtl/throw_pkg.sv
// -----------------------------------------------------------------------------
// throw_pkg
// Shared types and constants for the projectile (throw) stage.
//   - state_t    : trajectory FSM states
//   - q12_4_t    : signed Q12.4 fixed-point position / velocity
//   - to_q()     : integer pixels -> Q12.4
//   - to_pix()   : Q12.4 -> integer pixel (arithmetic shift, truncated)
// -----------------------------------------------------------------------------
package throw_pkg;

  localparam int FRAC_BITS = 4;
  localparam int FORCE_W   = 10;
  localparam int Q_W       = 16;
  localparam int PIX_W     = 11;

  typedef logic signed [Q_W-1:0] q12_4_t;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    FLIGHT,
    HOLD
  } state_t;

  function automatic q12_4_t to_q(input int px);
    return q12_4_t'(px * (1 << FRAC_BITS));
  endfunction

  function automatic logic [PIX_W-1:0] to_pix(input q12_4_t v);
    return PIX_W'(v >>> FRAC_BITS);
  endfunction

endpackage

// File: rtl/edge_detector.sv
// -----------------------------------------------------------------------------
// edge_detector
// Registers its input once and flags a single-cycle edge by comparing the live
// input against the registered copy.
//   clk, rst_n : clock, asynchronous active-low reset
//   sig        : level to watch
//   pulse      : high for the cycle in which the selected edge is seen
// Parameter FALLING selects a falling (1) or rising (0) edge.
// -----------------------------------------------------------------------------
module edge_detector #(
  parameter bit FALLING = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic pulse
);

  logic sig_d;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the values from before the clock edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_d <= 1'b0;
    else        sig_d <= sig;
  end

  assign pulse = FALLING ? (sig_d && !sig) : (sig && !sig_d);

endmodule

// File: rtl/throw_trajectory.sv
// -----------------------------------------------------------------------------
// throw_trajectory
// Launches a projectile when space is released, steps it once per video frame
// with Q12.4 ballistic physics, and reports position and landing / leaving the
// screen to the sprite and game-logic stages.
//   clk, rst_n     : clock, asynchronous active-low reset
//   space          : space key level (release triggers a throw)
//   throw_force    : power-bar force, valid the cycle after the release
//   vsync          : frame tick on its rising edge
//   proj_x, proj_y : projectile pixel position (proj_y is 0 above the screen)
//   proj_on        : projectile exists (in flight or held after landing)
//   proj_visible   : proj_on and the projectile is not above the screen
//   busy           : a throw is in progress
//   landed         : one-cycle pulse when the projectile lands
//   out_of_bounds  : one-cycle pulse when it leaves the screen horizontally
//   land_x         : x of the last landing, held until the next one
// -----------------------------------------------------------------------------
module throw_trajectory
  import throw_pkg::*;
#(
  parameter int X_LAUNCH    = 876,
  parameter int Y_LAUNCH    = 600,
  parameter int GROUND_Y    = 600,
  parameter int H_RES       = 1024,
  parameter int VX_GAIN     = 2,
  parameter int VY_GAIN     = 2,
  parameter int G_Q         = 4,
  parameter int HOLD_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               space,
  input  logic [FORCE_W-1:0] throw_force,
  input  logic               vsync,
  output logic [PIX_W-1:0]   proj_x,
  output logic [PIX_W-1:0]   proj_y,
  output logic               proj_on,
  output logic               proj_visible,
  output logic               busy,
  output logic               landed,
  output logic               out_of_bounds,
  output logic [PIX_W-1:0]   land_x
);

  localparam q12_4_t X0       = to_q(X_LAUNCH);
  localparam q12_4_t Y0       = to_q(Y_LAUNCH);
  localparam q12_4_t Y_GROUND = to_q(GROUND_Y);
  localparam q12_4_t X_MAX    = to_q(H_RES);
  localparam q12_4_t GRAVITY  = q12_4_t'(G_Q);
  localparam int     HOLD_W   = $clog2(HOLD_FRAMES + 1);

  logic space_release;
  logic frame_tick;

  edge_detector #(.FALLING(1'b1)) u_space_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (space),
    .pulse (space_release)
  );

  edge_detector #(.FALLING(1'b0)) u_vsync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (vsync),
    .pulse (frame_tick)
  );

  state_t            state;
  q12_4_t            x, y, vx, vy;
  logic [HOLD_W-1:0] hold_cnt;
  logic              land_evt, oob_evt;
  logic [PIX_W-1:0]  land_x_q;

  q12_4_t force_q, vx_init, vy_init, x_step, y_step;
  logic   off_screen, hit_ground;

  // NOTE: every signal driven here is assigned on every path through the
  // block, so no latch can be inferred.
  always_comb begin
    force_q    = q12_4_t'({{(Q_W-FORCE_W){1'b0}}, throw_force});
    vx_init    = force_q * q12_4_t'(VX_GAIN);
    vy_init    = -(force_q * q12_4_t'(VY_GAIN));
    // Positions advance with the velocity held before this frame's gravity.
    x_step     = x - vx;
    y_step     = y + vy;
    off_screen = (x_step < q12_4_t'(0)) || (x_step >= X_MAX);
    hit_ground = (y_step >= Y_GROUND);
  end

  // Trajectory FSM and physics state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      vx       <= '0;
      vy       <= '0;
      hold_cnt <= '0;
      land_evt <= 1'b0;
      oob_evt  <= 1'b0;
      land_x_q <= '0;
    end else begin
      land_evt <= 1'b0;
      oob_evt  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (space_release) state <= ARM;
        end
        // Force is only valid now, one cycle after the release; any frame
        // tick landing in this cycle is deliberately dropped.
        ARM: begin
          if (throw_force == '0) begin
            state <= IDLE;
          end else begin
            x     <= X0;
            y     <= Y0;
            vx    <= vx_init;
            vy    <= vy_init;
            state <= FLIGHT;
          end
        end
        FLIGHT: begin
          if (frame_tick) begin
            x  <= x_step;
            y  <= y_step;
            vy <= vy + GRAVITY;
            // Leaving the screen takes priority over touching the ground.
            if (off_screen) begin
              oob_evt <= 1'b1;
              state   <= IDLE;
            end else if (hit_ground) begin
              y        <= Y_GROUND;
              land_x_q <= to_pix(x_step);
              land_evt <= 1'b1;
              hold_cnt <= '0;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (frame_tick) begin
            if (hold_cnt == HOLD_W'(HOLD_FRAMES - 1)) state <= IDLE;
            else                                       hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register stage: everything downstream sees is taken from the
  // state/position registers one cycle later.
  logic on_next;
  assign on_next = (state == FLIGHT) || (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proj_x        <= '0;
      proj_y        <= '0;
      proj_on       <= 1'b0;
      proj_visible  <= 1'b0;
      busy          <= 1'b0;
      landed        <= 1'b0;
      out_of_bounds <= 1'b0;
      land_x        <= '0;
    end else begin
      proj_x        <= to_pix(x);
      proj_y        <= y[Q_W-1] ? '0 : to_pix(y);
      proj_on       <= on_next;
      proj_visible  <= on_next && !y[Q_W-1];
      busy          <= (state != IDLE);
      landed        <= land_evt;
      out_of_bounds <= oob_evt;
      land_x        <= land_x_q;
    end
  end

endmodule

// File: tb/tb_throw_trajectory.sv
// -----------------------------------------------------------------------------
// tb_throw_trajectory
// Directed and randomized throws against a closed-form ballistic model.
// -----------------------------------------------------------------------------
module tb_throw_trajectory;

  localparam int X_LAUNCH    = 876;
  localparam int Y_LAUNCH    = 600;
  localparam int GROUND_Y    = 600;
  localparam int H_RES       = 1024;
  localparam int VX_GAIN     = 2;
  localparam int VY_GAIN     = 2;
  localparam int G_Q         = 4;
  localparam int HOLD_FRAMES = 30;
  localparam int TICK_BUDGET = 250;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        space = 1'b0;
  logic [9:0]  throw_force = '0;
  logic        vsync = 1'b0;
  logic [10:0] proj_x, proj_y, land_x;
  logic        proj_on, proj_visible, busy, landed, out_of_bounds;

  throw_trajectory dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .space         (space),
    .throw_force   (throw_force),
    .vsync         (vsync),
    .proj_x        (proj_x),
    .proj_y        (proj_y),
    .proj_on       (proj_on),
    .proj_visible  (proj_visible),
    .busy          (busy),
    .landed        (landed),
    .out_of_bounds (out_of_bounds),
    .land_x        (land_x)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int tick_no = 0;

  // Event monitor, sampled away from the active edge.
  int land_cnt = 0, oob_cnt = 0, on_cnt = 0, busy_cnt = 0, wide_cnt = 0;
  int land_tick = -1, oob_tick = -1;
  logic landed_prev = 1'b0, oob_prev = 1'b0;

  always @(negedge clk) begin
    if (landed)        begin land_cnt++; land_tick = tick_no; end
    if (out_of_bounds) begin oob_cnt++;  oob_tick  = tick_no; end
    if ((landed && landed_prev) || (out_of_bounds && oob_prev)) wide_cnt++;
    landed_prev = landed;
    oob_prev    = out_of_bounds;
    if (proj_on) on_cnt++;
    if (busy)    busy_cnt++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Closed-form model: position after n frames of constant gravity.
  function automatic int model_x(input int f, input int n);
    return X_LAUNCH * 16 - f * VX_GAIN * n;
  endfunction

  function automatic int model_y(input int f, input int n);
    return Y_LAUNCH * 16 - f * VY_GAIN * n + (G_Q * n * (n - 1)) / 2;
  endfunction

  task automatic predict(input int f, output bit lands, output int n_evt, output int lx);
    lands = 1'b0; n_evt = -1; lx = 0;
    for (int n = 1; n < 1000; n++) begin
      if (model_x(f, n) < 0 || model_x(f, n) >= H_RES * 16) begin
        n_evt = n; return;
      end
      if (model_y(f, n) >= GROUND_Y * 16) begin
        lands = 1'b1; n_evt = n; lx = model_x(f, n) / 16; return;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    tick_no = tick_no + 1;
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic press_release(input int f);
    @(negedge clk) space = 1'b1;
    repeat (3) @(negedge clk);
    space = 1'b0;
    throw_force = 10'(f);
  endtask

  task automatic launch(input int f, input bit arm_tick);
    press_release(f);
    @(negedge clk);
    if (arm_tick) vsync = 1'b1;   // rises so the edge is seen during ARM
    @(negedge clk);
    if (f != 0) check("busy_after_launch", busy, 1);
    @(negedge clk);
    vsync = 1'b0;
    if (f != 0) begin
      check("on_after_launch", proj_on, 1);
      check("launch_x", proj_x, X_LAUNCH);
      check("launch_y", proj_y, Y_LAUNCH);
    end
    tick_no = 0;
  endtask

  task automatic fly(input int f, input int lock_at, input int abort_at, output bit lands);
    int n_evt, lx, l0, o0, yq;
    predict(f, lands, n_evt, lx);
    l0 = land_cnt;
    o0 = oob_cnt;
    while (land_cnt == l0 && oob_cnt == o0 && tick_no < TICK_BUDGET) begin
      if (abort_at > 0 && tick_no == abort_at) return;
      if (lock_at > 0 && tick_no == lock_at) press_release(100);
      tick();
      if (land_cnt == l0 && oob_cnt == o0 && tick_no < n_evt) begin
        yq = model_y(f, tick_no);
        check("flight_x", proj_x, model_x(f, tick_no) / 16);
        check("flight_y", proj_y, (yq < 0) ? 0 : yq / 16);
        check("flight_visible", proj_visible, (yq >= 0) ? 1 : 0);
      end
    end
    check("event_seen", (land_cnt != l0 || oob_cnt != o0) ? 1 : 0, 1);
    check("event_tick", (land_cnt != l0) ? land_tick : oob_tick, n_evt);
    check("landed_pulses", land_cnt - l0, lands ? 1 : 0);
    check("oob_pulses", oob_cnt - o0, lands ? 0 : 1);
    if (lands) begin
      check("land_x", land_x, lx);
      check("land_proj_x", proj_x, lx);
      check("land_proj_y", proj_y, GROUND_Y);
      check("land_visible", proj_visible, 1);
    end else begin
      check("oob_busy", busy, 0);
      check("oob_on", proj_on, 0);
    end
  endtask

  task automatic hold_phase();
    for (int i = 1; i < HOLD_FRAMES; i++) tick();
    check("hold_on_before_end", proj_on, 1);
    tick();
    check("hold_on_after_end", proj_on, 0);
    check("hold_busy_after_end", busy, 0);
  endtask

  initial begin
    bit lands;
    int l0, o0, b0, c0, f;

    // Reset state
    @(negedge clk);
    check("rst_proj_x", proj_x, 0);
    check("rst_proj_y", proj_y, 0);
    check("rst_flags", {proj_on, proj_visible, busy, landed, out_of_bounds}, 0);
    check("rst_land_x", land_x, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_busy_cnt", busy_cnt, 0);
    check("idle_on_cnt", on_cnt, 0);

    // Force 64: lands on frame 65 at x = 356, then holds for 30 frames
    launch(64, 1'b0);
    fly(64, 0, 0, lands);
    check("f64_lands", lands, 1);
    check("f64_land_x", land_x, 356);
    hold_phase();

    // Force 128: leaves the screen on frame 55, land_x untouched
    launch(128, 1'b0);
    fly(128, 0, 0, lands);
    check("f128_oob", lands, 0);
    check("f128_land_x_kept", land_x, 356);

    // Force 0: one cycle of ARM, nothing launched
    l0 = land_cnt; o0 = oob_cnt; b0 = busy_cnt; c0 = on_cnt;
    launch(0, 1'b0);
    repeat (6) @(negedge clk);
    check("f0_busy_cycles", busy_cnt - b0, 1);
    check("f0_on_cycles", on_cnt - c0, 0);
    check("f0_pulses", (land_cnt - l0) + (oob_cnt - o0), 0);
    check("f0_busy", busy, 0);

    // Busy lockout: a second release mid-flight is ignored
    launch(64, 1'b0);
    fly(64, 10, 0, lands);
    check("lock_land_tick", land_tick, 65);
    check("lock_land_x", land_x, 356);
    hold_phase();

    // Reset mid-flight, then relaunch with a tick during ARM
    launch(64, 1'b0);
    fly(64, 0, 20, lands);
    l0 = land_cnt; o0 = oob_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_flags", {proj_on, proj_visible, busy, landed, out_of_bounds}, 0);
    check("midrst_pos", {proj_x, proj_y}, 0);
    check("midrst_land_x", land_x, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("midrst_no_pulse", (land_cnt - l0) + (oob_cnt - o0), 0);
    launch(64, 1'b1);
    fly(64, 0, 0, lands);
    check("armtick_land_tick", land_tick, 65);
    hold_phase();

    // Randomized forces against the model
    for (int k = 0; k < 5; k++) begin
      f = $urandom_range(1, 200);
      launch(f, k[0]);
      fly(f, 0, 0, lands);
      if (lands) hold_phase();
    end

    check("pulse_width", wide_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
